mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-port arbiter that shares the single SRAM-like memory bus between the fetch stage (instruction reads) and the memory stage (data reads/writes). It sits between the datapath's fetch/memory stages and the external bus. It serialises requests with one outstanding transaction at a time, and latches the winning request. It returns per-requester `data_ok`, which the hazard unit uses as the stall source for `stallF` and `stallM`.

## Interface
Parameters:
- `DATA_FIRST`, default 1: when both ports request in the same IDLE cycle, 1 grants data and 0 grants instruction.

Ports:
- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch requests an instruction read; held until `i_data_ok`.
- `i_addr`  in  32  instruction address (`word_t`).
- `i_rdata`  out  32  instruction returned; valid when `i_data_ok`.
- `i_data_ok`  out  1  one-cycle pulse: fetch transaction complete.
- `d_req`  in  1  memory stage requests; held until `d_data_ok`.
- `d_wr`  in  1  1 = write, 0 = read.
- `d_size`  in  2  0 = byte, 1 = half, 2 = word.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `d_rdata`  out  32  load data; valid when `d_data_ok`.
- `d_data_ok`  out  1  one-cycle pulse: data transaction complete.
- `bus_req`  out  1  request to the bus.
- `bus_wr`  out  1  write flag of the latched request.
- `bus_size`  out  2  size of the latched request.
- `bus_addr`  out  32  address of the latched request.
- `bus_wdata`  out  32  store data of the latched request.
- `bus_addr_ok`  in  1  bus accepted the address.
- `bus_data_ok`  in  1  bus completed the transaction.
- `bus_rdata`  in  32  read data from the bus.

## Operation
- FSM states, encoded as `arb_state_t`: IDLE, ADDR, DATA.
- Owner register `owner`: NONE, INST or DATA.
- In IDLE, with any request pending:
  - Choose a winner by `DATA_FIRST`.
  - Latch the winner's addr/wr/size/wdata. Instruction requests are forced to wr=0 and size=2.
  - Set `owner` and go to ADDR.
- ADDR:
  - `bus_req`=1, driving the latched fields.
  - On `bus_addr_ok`, go to DATA.
  - If `bus_data_ok` is also high in that same cycle, complete immediately and go to IDLE.
- DATA:
  - Wait for `bus_data_ok`.
  - On it, pulse the owner's `x_data_ok` combinationally in the same cycle and go to IDLE.
- `i_rdata` and `d_rdata` both pass `bus_rdata` through combinationally. They are only meaningful together with their `data_ok`.
- The latched fields are immune to requester changes after the grant.
- A requester that drops `req` mid-transaction (flush) does not abort the transaction. The transaction runs to completion and `data_ok` still pulses; the requester discards it.
- `bus_data_ok` in IDLE, or `bus_addr_ok` outside ADDR, is ignored.
- A request arriving while busy waits; there is no queueing beyond the requester holding `req`.

## Timing
- Reset (async, `resetn`=0):
  - state=IDLE, `owner`=NONE.
  - `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wdata` = 0.
  - `i_data_ok`, `d_data_ok` = 0.
- Reset mid-transaction drops everything. The bus is assumed reset together with the arbiter.
- Best-case latency, with the request seen in cycle 0:
  - `bus_req` rises in cycle 1.
  - With `bus_addr_ok` in cycle 1 and `bus_data_ok` in cycle 2, `x_data_ok` pulses in cycle 2.
  - Same-cycle addr_ok+data_ok in cycle 1 gives `x_data_ok` in cycle 1.
- Back-to-back: after the completion cycle the FSM spends one IDLE cycle granting. Consecutive transactions are therefore 1 bubble apart at minimum.
- `bus_req` is a registered-state decode (state==ADDR) and is glitch-free.
- `x_data_ok` is high for exactly one cycle per granted transaction. Both `data_ok` outputs are never high together.

## Structure
- In the shared package, next to `word_t`/`m_r_t`/`m_w_t`:
  - `arb_state_t` enum.
  - `arb_owner_t` enum.
  - `bus_req_t` struct {wr, size, addr, wdata}, the latched request.
  - Constants `MSIZE_BYTE`/`MSIZE_HALF`/`MSIZE_WORD`.
- No sub-module is needed. The arbiter is one FSM plus the latch register.
- The hazard unit derives `stallF = i_req & ~i_data_ok` and `stallM = d_req & ~d_data_ok`.

## Test plan
- Single instruction fetch:
  - Stimulus: `i_req`=1 with `i_addr`=0xBFC00000; the bus answers addr_ok in cycle 1 and data_ok with rdata=0x3C080001 in cycle 3.
  - Required: `bus_req` high cycles 1–1, `bus_addr`=0xBFC00000, `bus_wr`=0, `bus_size`=2; `i_data_ok` pulses in cycle 3 with `i_rdata`=0x3C080001.
- Simultaneous requests, `DATA_FIRST`=1:
  - Stimulus: `i_req`=1 and `d_req`=1 (sw, 0x80001000, data 0xDEADBEEF) in cycle 0.
  - Required: the data transaction goes first with `bus_wr`=1 and `bus_wdata`=0xDEADBEEF; after `d_data_ok`, there is one IDLE cycle, then the instruction transaction is issued.
- Slow bus:
  - Stimulus: `bus_addr_ok` delayed 4 cycles; `d_addr` changed to 0x0 during the wait.
  - Required: `bus_req` is held for 4 cycles and `bus_addr` stays 0x80001000.
- Same-cycle completion:
  - Stimulus: `bus_addr_ok`=`bus_data_ok`=1 in cycle 1.
  - Required: `x_data_ok` in cycle 1 and state back to IDLE in cycle 2.
- Flush:
  - Stimulus: `i_req` dropped while in DATA.
  - Required: `i_data_ok` still pulses once; no new `bus_req` is issued afterwards.
- Reset mid-transaction:
  - Stimulus: `resetn`=0 while in ADDR.
  - Required: `bus_req`=0 immediately (asynchronously), and no `data_ok` fires after reset is released.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-interface types: word/bus request structs, size codes, arbiter FSM enums.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_bus_arbiter_pkg;

  typedef logic [31:0] word_t;

  // Generic read / write request shapes used by the datapath memory ports.
  typedef struct packed {
    logic  req;
    word_t addr;
  } m_r_t;

  typedef struct packed {
    logic       req;
    logic [1:0] size;
    word_t      addr;
    word_t      wdata;
  } m_w_t;

  // Access size codes carried on bus_size.
  localparam logic [1:0] MSIZE_BYTE = 2'd0;
  localparam logic [1:0] MSIZE_HALF = 2'd1;
  localparam logic [1:0] MSIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } arb_owner_t;

  // Request latched at grant time and driven onto the bus until completion.
  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    word_t      addr;
    word_t      wdata;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch (inst reads) and memory stage (data rd/wr), one transaction at a time.
// Latency: bus_req the cycle after a request is seen; x_data_ok is combinational with bus_data_ok.
// Backpressure: requesters hold req until their data_ok; a waiting request is held off until the bus is free.
//
// Ports:
//   clk, resetn                         clock, async active-low reset
//   i_req/i_addr -> i_rdata/i_data_ok   fetch port (read-only, word size)
//   d_req/d_wr/d_size/d_addr/d_wdata    memory-stage port
//     -> d_rdata/d_data_ok
//   bus_req/bus_wr/bus_size/bus_addr/bus_wdata -> external bus, driven from the latched request
//   bus_addr_ok/bus_data_ok/bus_rdata   <- external bus handshake and read data
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_data_ok,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_data_ok,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  arb_state_t state_q;
  arb_owner_t owner_q;
  bus_req_t   breq_q;

  logic grant_d;
  logic done;

  // Data wins a tie only when DATA_FIRST is set; otherwise it needs fetch idle.
  assign grant_d = d_req & (DATA_FIRST | ~i_req);

  // Transaction completes either on a same-cycle addr_ok+data_ok or on data_ok in DATA.
  assign done = ((state_q == ARB_ADDR) & bus_addr_ok & bus_data_ok) |
                ((state_q == ARB_DATA) & bus_data_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      breq_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant_d) begin
            breq_q.wr    <= d_wr;
            breq_q.size  <= d_size;
            breq_q.addr  <= d_addr;
            breq_q.wdata <= d_wdata;
            owner_q      <= OWN_DATA;
            state_q      <= ARB_ADDR;
          end else if (i_req) begin
            // Fetch is always a word read; wdata is irrelevant for reads.
            breq_q.wr    <= 1'b0;
            breq_q.size  <= MSIZE_WORD;
            breq_q.addr  <= i_addr;
            breq_q.wdata <= '0;
            owner_q      <= OWN_INST;
            state_q      <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (bus_addr_ok) begin
            if (bus_data_ok) begin
              owner_q <= OWN_NONE;
              state_q <= ARB_IDLE;
            end else begin
              state_q <= ARB_DATA;
            end
          end
        end
        ARB_DATA: begin
          if (bus_data_ok) begin
            owner_q <= OWN_NONE;
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          owner_q <= OWN_NONE;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // Pure decode of registered state, so bus_req cannot glitch.
  assign bus_req   = (state_q == ARB_ADDR);
  assign bus_wr    = breq_q.wr;
  assign bus_size  = breq_q.size;
  assign bus_addr  = breq_q.addr;
  assign bus_wdata = breq_q.wdata;

  assign i_data_ok = done & (owner_q == OWN_INST);
  assign d_data_ok = done & (owner_q == OWN_DATA);
  assign i_rdata   = bus_rdata;
  assign d_rdata   = bus_rdata;

endmodule
